// File: rtl/uart_tx_chan.sv
// uart_tx_chan
// ------------
// Single-channel UART transmitter. Words enter a small FIFO and leave the
// block as 8N1 frames (LSB first) on uart_tx. Control words (bit 9 set)
// turn a line BREAK on (bit 0 = 1) or off (bit 0 = 0). A BREAK lasts at
// least BREAK_MIN_BITS bit times, even when the off request arrives early.
// Each BREAK is followed by one bit time of mark.
//
// Parameters
//   DIVIDER        clocks per bit time (>= 2)
//   FIFO_LOG2      input FIFO depth is 2**FIFO_LOG2 words (>= 1)
//   BREAK_MIN_BITS minimum BREAK length in bit times
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   uart_indata_stb  write strobe, one word per asserted cycle
//   uart_indata_data [9] CONTROL, [8] reserved, [7:0] payload / [0] BREAK on
//   uart_tx          serial line, idle high
//   busy             FIFO non-empty, state not IDLE, or line stage active
//   full             FIFO holds 2**FIFO_LOG2 words (registered)
//   ovr              one-cycle pulse after a write was dropped on full
//   err              one-cycle pulse after a data word was discarded in BREAK
module uart_tx_chan #(
  parameter int DIVIDER        = 32,
  parameter int FIFO_LOG2      = 2,
  parameter int BREAK_MIN_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_indata_stb,
  input  logic [9:0] uart_indata_data,
  output logic       uart_tx,
  output logic       busy,
  output logic       full,
  output logic       ovr,
  output logic       err
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W = $clog2(DIVIDER);
  localparam int BRK_W = $clog2(BREAK_MIN_BITS + 1);

  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(DIVIDER - 1);
  localparam logic [BRK_W-1:0]   BRK_MIN   = BRK_W'(BREAK_MIN_BITS);
  localparam logic [FIFO_LOG2:0] FIFO_FULL = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK,
    S_MARK
  } state_t;

  // ---------------------------------------------------------------------
  // Input FIFO. Bit 8 of a word carries no meaning, so the FIFO stores
  // only {CONTROL, payload}.
  // ---------------------------------------------------------------------
  logic [8:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic [FIFO_LOG2:0]   count_next;
  logic                 do_write;
  logic                 do_pop;
  logic                 fifo_empty;
  logic [8:0]           head;
  logic                 head_ctrl;
  logic                 head_bit0;

  state_t               state;

  logic unused_rsvd;
  assign unused_rsvd = uart_indata_data[8];

  // The registered full flag gates writes, so a pop in the same cycle
  // never makes room for a write into a full FIFO.
  assign do_write   = uart_indata_stb && !full;
  assign fifo_empty = (count == '0);
  assign do_pop     = !fifo_empty && ((state == S_IDLE) || (state == S_BREAK));
  assign head       = mem[rd_ptr];
  assign head_ctrl  = head[8];
  assign head_bit0  = head[0];

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    count_next = count;
    if (do_write && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_write && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and occupancy
  // counter define which entries are valid, so clearing them empties it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {uart_indata_data[9], uart_indata_data[7:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FIFO_FULL);
      ovr   <= uart_indata_stb && full;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic [BRK_W-1:0] brk_cnt;
  logic [BRK_W-1:0] brk_cnt_next;
  logic             end_req;
  logic             end_seen;
  logic             bit_last;
  logic             line_active;
  logic             tx_now;

  assign bit_last = (bit_cnt == BIT_LAST);

  // The end request can be honoured in the very cycle the off word is
  // popped, so a late request ends the BREAK without an extra clock.
  assign end_seen = end_req || (do_pop && head_ctrl && !head_bit0);

  always_comb begin
    brk_cnt_next = brk_cnt;
    if (bit_last && (brk_cnt != BRK_MIN)) begin
      brk_cnt_next = brk_cnt + 1'b1;
    end
  end

  // Line level for the current state; it is registered into uart_tx, so
  // the line lags the state by exactly one clock throughout.
  always_comb begin
    tx_now = 1'b1;
    case (state)
      S_START, S_BREAK: tx_now = 1'b0;
      S_DATA:           tx_now = data_q[bit_idx];
      default:          tx_now = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      data_q      <= '0;
      brk_cnt     <= '0;
      end_req     <= 1'b0;
      line_active <= 1'b0;
      uart_tx     <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err         <= 1'b0;
      uart_tx     <= tx_now;
      line_active <= (state != S_IDLE);
      // line_active keeps busy high until the last registered line bit
      // has been driven out.
      busy        <= !fifo_empty || (state != S_IDLE) || line_active;

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (do_pop) begin
            if (!head_ctrl) begin
              data_q  <= head[7:0];
              bit_idx <= '0;
              state   <= S_START;
            end else if (head_bit0) begin
              brk_cnt <= '0;
              end_req <= 1'b0;
              state   <= S_BREAK;
            end
          end
        end

        S_START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
          brk_cnt <= brk_cnt_next;
          if (do_pop && head_ctrl && !head_bit0) end_req <= 1'b1;
          if (do_pop && !head_ctrl)              err     <= 1'b1;
          if (end_seen && (brk_cnt_next == BRK_MIN)) begin
            bit_cnt <= '0;
            end_req <= 1'b0;
            state   <= S_MARK;
          end
        end

        S_MARK: begin
          if (bit_last) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
